// File: rtl/mdu_pipe.sv
// mdu_pipe: E-stage multiply/divide unit that owns the HI/LO registers.
// The result is computed in the accept cycle and held in pending registers.
// A down-counter then models the fixed latency; the result is committed when
// the count expires, so the stall timing matches the real multi-cycle unit.
// Optional feature macro: MDU_MADD_EN enables MADD/MSUB (op 6/7) accumulation
// onto {hi,lo}. Without it, op 6/7 are ignored.
module mdu_pipe #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_MADD  = 3'd6,
        OP_MSUB  = 3'd7
    } op_e;

    op_e         op_q;
    logic [3:0]  counter;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;
    logic        pend_wr;

    logic        is_mul;
    logic        is_div;
    logic        is_acc;
    logic        multi_op;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        div_signed;
    logic [31:0] rs_mag;
    logic [31:0] rt_mag;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quot_raw;
    logic [31:0] rem_raw;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [63:0] result;
    logic        result_wr;
    logic [3:0]  latency;

    assign op_q   = op_e'(op);
    assign is_mul = (op_q == OP_MULT) || (op_q == OP_MULTU);
    assign is_div = (op_q == OP_DIV)  || (op_q == OP_DIVU);
`ifdef MDU_MADD_EN
    assign is_acc = (op_q == OP_MADD) || (op_q == OP_MSUB);
`else
    assign is_acc = 1'b0;
`endif
    assign multi_op  = is_mul || is_div || is_acc;
    assign stall_req = busy || (start && multi_op);
    assign latency   = is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);

    // Operand datapath: 64-bit products and a shared sign-magnitude divider.
    // The divider works on magnitudes so 0x80000000 / -1 wraps to 0x80000000
    // naturally instead of relying on signed-divide overflow behaviour.
    always_comb begin
        prod_s     = $signed({{32{rs_data[31]}}, rs_data}) * $signed({{32{rt_data[31]}}, rt_data});
        prod_u     = {32'd0, rs_data} * {32'd0, rt_data};
        div_signed = (op_q == OP_DIV);
        rs_mag     = rs_data[31] ? (~rs_data + 32'd1) : rs_data;
        rt_mag     = rt_data[31] ? (~rt_data + 32'd1) : rt_data;
        dividend   = div_signed ? rs_mag : rs_data;
        divisor    = div_signed ? rt_mag : rt_data;
        if (divisor == 32'd0) begin
            divisor = 32'd1;
        end
        quot_raw = dividend / divisor;
        rem_raw  = dividend % divisor;
        quot     = quot_raw;
        rem      = rem_raw;
        if (div_signed && (rs_data[31] != rt_data[31])) begin
            quot = ~quot_raw + 32'd1;
        end
        if (div_signed && rs_data[31]) begin
            rem = ~rem_raw + 32'd1;
        end
    end

    // Select the 64-bit result for the accepted op; divide by zero suppresses the write.
    always_comb begin
        result    = 64'd0;
        result_wr = 1'b1;
        case (op_q)
            OP_MULT:  result = prod_s;
            OP_MULTU: result = prod_u;
            OP_DIV, OP_DIVU: begin
                result    = {rem, quot};
                result_wr = (rt_data != 32'd0);
            end
`ifdef MDU_MADD_EN
            OP_MADD:  result = {hi, lo} + prod_s;
            OP_MSUB:  result = {hi, lo} - prod_s;
`endif
            default: begin
                result    = 64'd0;
                result_wr = 1'b0;
            end
        endcase
    end

    // Accept, latency countdown and HI/LO commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi      <= 32'd0;
            lo      <= 32'd0;
            busy    <= 1'b0;
            counter <= 4'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_wr <= 1'b0;
        end else if (busy) begin
            if (counter == 4'd1) begin
                busy    <= 1'b0;
                counter <= 4'd0;
                if (pend_wr) begin
                    hi <= pend_hi;
                    lo <= pend_lo;
                end
            end else begin
                counter <= counter - 4'd1;
            end
        end else if (start) begin
            if (op_q == OP_MTHI) begin
                hi <= rs_data;
            end else if (op_q == OP_MTLO) begin
                lo <= rs_data;
            end else if (multi_op) begin
                pend_hi <= result[63:32];
                pend_lo <= result[31:0];
                pend_wr <= result_wr;
                counter <= latency;
                busy    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mdu_pipe.sv
// tb_mdu_pipe: directed and randomized checks of mdu_pipe against a
// plain-arithmetic model of HI/LO and the expected busy latency.
module tb_mdu_pipe;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    typedef struct {
        logic [31:0] h;
        logic [31:0] l;
        int          n;
    } exp_t;

    mdu_pipe #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .busy      (busy),
        .stall_req (stall_req),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] h, input logic [31:0] l);
        exp_t   e;
        longint sa, sb, q, r;
        logic [63:0] acc;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        e.h = h;
        e.l = l;
        e.n = 0;
        acc = {h, l};
        case (o)
            3'd0: begin acc = 64'(sa * sb); e.h = acc[63:32]; e.l = acc[31:0]; e.n = MC; end
            3'd1: begin acc = {32'd0, a} * {32'd0, b}; e.h = acc[63:32]; e.l = acc[31:0]; e.n = MC; end
            3'd2: begin
                e.n = DC;
                if (b != 0) begin
                    q = sa / sb;
                    r = sa % sb;
                    e.l = q[31:0];
                    e.h = r[31:0];
                end
            end
            3'd3: begin
                e.n = DC;
                if (b != 0) begin
                    e.l = a / b;
                    e.h = a % b;
                end
            end
            3'd4: e.h = a;
            3'd5: e.l = a;
`ifdef MDU_MADD_EN
            3'd6: begin acc = acc + 64'(sa * sb); e.h = acc[63:32]; e.l = acc[31:0]; e.n = MC; end
            3'd7: begin acc = acc - 64'(sa * sb); e.h = acc[63:32]; e.l = acc[31:0]; e.n = MC; end
`endif
            default: e.n = 0;
        endcase
        return e;
    endfunction

    // Present an op for exactly one accept edge; reports stall_req in the issue cycle.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, output logic st);
        @(negedge clk);
        start   = 1'b1;
        op      = o;
        rs_data = a;
        rt_data = b;
        #1 st = stall_req;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count busy and stall cycles until idle, bounded so a stuck busy cannot hang.
    task automatic wait_idle(output int nb, output int ns);
        nb = 0;
        ns = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (!busy) break;
            nb++;
            if (stall_req) ns++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        op = 3'd0;
        rs_data = 32'd0;
        rt_data = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || stall_req !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            n_err++;
            $display("FAIL reset_state: got busy=%b stall=%b hi=%h lo=%h, want 0 0 0 0", busy, stall_req, hi, lo);
        end
        exp_hi = 32'd0;
        exp_lo = 32'd0;
    endtask

    task automatic run_check(input string name, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic st;
        int nb, ns;
        e = model(o, a, b, exp_hi, exp_lo);
        issue(o, a, b, st);
        wait_idle(nb, ns);
        n_cmp++;
        if (st !== (e.n != 0) || nb != e.n || ns != e.n) begin
            n_err++;
            $display("FAIL %s_timing: got issue_stall=%b busy=%0d stall=%0d, want %b %0d %0d",
                     name, st, nb, ns, (e.n != 0), e.n, e.n);
        end
        n_cmp++;
        if (hi !== e.h || lo !== e.l) begin
            n_err++;
            $display("FAIL %s_result: got hi=%h lo=%h, want hi=%h lo=%h", name, hi, lo, e.h, e.l);
        end
        exp_hi = e.h;
        exp_lo = e.l;
    endtask

    task automatic test_mult;
        exp_t e;
        e = model(3'd0, 32'hFFFFFFFD, 32'd7, exp_hi, exp_lo);
        n_cmp++;
        if (e.h !== 32'hFFFFFFFF || e.l !== 32'hFFFFFFEB) begin
            n_err++;
            $display("FAIL model_mult: got %h_%h, want ffffffff_ffffffeb", e.h, e.l);
        end
        run_check("mult", 3'd0, 32'hFFFFFFFD, 32'd7);
        run_check("multu", 3'd1, 32'hFFFFFFFF, 32'd2);
        n_cmp++;
        if (hi !== 32'h1 || lo !== 32'hFFFFFFFE) begin
            n_err++;
            $display("FAIL multu_const: got hi=%h lo=%h, want 00000001 fffffffe", hi, lo);
        end
    endtask

    task automatic test_div_midflight;
        logic st;
        int nb, ns;
        logic [31:0] lo_before;
        lo_before = lo;
        issue(3'd2, 32'hFFFFFFF9, 32'd2, st);
        repeat (2) @(negedge clk);
        start   = 1'b1;
        op      = 3'd5;
        rs_data = 32'h1234;
        @(negedge clk);
        start = 1'b0;
        #1;
        n_cmp++;
        if (lo !== lo_before || busy !== 1'b1) begin
            n_err++;
            $display("FAIL mtlo_ignored: got lo=%h busy=%b, want lo=%h busy=1", lo, busy, lo_before);
        end
        wait_idle(nb, ns);
        n_cmp++;
        if (nb != DC - 3 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
            n_err++;
            $display("FAIL div_midflight: got rest_busy=%0d hi=%h lo=%h, want %0d ffffffff fffffffd",
                     nb, hi, lo, DC - 3);
        end
        exp_hi = 32'hFFFFFFFF;
        exp_lo = 32'hFFFFFFFD;
    endtask

    task automatic test_divu_zero;
        run_check("mthi_aaaa", 3'd4, 32'hAAAA, 32'd0);
        run_check("mtlo_5555", 3'd5, 32'h5555, 32'd0);
        run_check("divu_zero", 3'd3, 32'h1357, 32'd0);
        n_cmp++;
        if (hi !== 32'hAAAA || lo !== 32'h5555) begin
            n_err++;
            $display("FAIL divu_zero_const: got hi=%h lo=%h, want 0000aaaa 00005555", hi, lo);
        end
        run_check("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF);
        n_cmp++;
        if (hi !== 32'd0 || lo !== 32'h80000000) begin
            n_err++;
            $display("FAIL div_ovf_const: got hi=%h lo=%h, want 00000000 80000000", hi, lo);
        end
    endtask

    task automatic test_mthi;
        logic st;
        issue(3'd4, 32'hDEADBEEF, 32'd0, st);
        #1;
        n_cmp++;
        if (hi !== 32'hDEADBEEF || busy !== 1'b0 || st !== 1'b0) begin
            n_err++;
            $display("FAIL mthi_idle: got hi=%h busy=%b stall=%b, want deadbeef 0 0", hi, busy, st);
        end
        exp_hi = 32'hDEADBEEF;
    endtask

    task automatic test_op67;
`ifdef MDU_MADD_EN
        run_check("madd", 3'd6, 32'hFFFFFFFF, 32'd9);
        run_check("msub", 3'd7, 32'd100, 32'hFFFFFFFE);
`else
        run_check("op6_noop", 3'd6, 32'd3, 32'd4);
        run_check("op7_noop", 3'd7, 32'd3, 32'd4);
`endif
    endtask

    task automatic test_reset_mid;
        logic st;
        int bad;
        issue(3'd0, 32'd3, 32'd4, st);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            n_err++;
            $display("FAIL reset_mid: got busy=%b hi=%h lo=%h, want 0 0 0", busy, hi, lo);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (lo !== 32'd0 || hi !== 32'd0 || busy !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL reset_discard: got %0d cycles with nonzero hi/lo or busy, want 0", bad);
        end
        exp_hi = 32'd0;
        exp_lo = 32'd0;
`ifdef MDU_MADD_EN
        run_check("mtlo_5", 3'd5, 32'd5, 32'd0);
        run_check("madd_3x4", 3'd6, 32'd3, 32'd4);
        n_cmp++;
        if (hi !== 32'd0 || lo !== 32'd17) begin
            n_err++;
            $display("FAIL madd_const: got hi=%h lo=%h, want 0 17", hi, lo);
        end
`endif
    endtask

    task automatic test_random;
        logic [31:0] corners [5];
        logic [31:0] a, b;
        logic [2:0]  o;
        corners[0] = 32'd0;
        corners[1] = 32'd1;
        corners[2] = 32'hFFFFFFFF;
        corners[3] = 32'h80000000;
        corners[4] = 32'h7FFFFFFF;
        for (int i = 0; i < 60; i++) begin
            o = 3'($urandom_range(0, 7));
            a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            if ($urandom_range(0, 7) == 0) b = 32'd0 | b[3:0];
            run_check("random", o, a, b);
        end
    endtask

    initial begin
        test_reset;
        test_mult;
        test_div_midflight;
        test_divu_zero;
        test_mthi;
        test_op67;
        test_reset_mid;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
